// File: rtl/fp_carpma_param.sv
// fp_carpma_param: iterative IEEE-754 multiplier with parametrised format,
// shift-add mantissa product (BPC bits per cycle), round-to-nearest-even,
// zero/inf/NaN handling, overflow/underflow saturation and valid/ready control.
module fp_carpma_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BPC   = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   gecerli_i,
    output logic                   hazir_o,
    input  logic [EXP_W+MAN_W:0]   x1_i,
    input  logic [EXP_W+MAN_W:0]   x2_i,
    output logic [EXP_W+MAN_W:0]   sonuc_o,
    output logic                   gecerli_o,
    output logic [3:0]             bayrak_o
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int N     = (MAN_W + 1) / BPC;
    localparam int AW    = 2 * (MAN_W + 1);
    localparam int EW2   = EXP_W + 2;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(N - 1);
    localparam logic [EW2-1:0]        BIAS_C   = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW2-1:0] EMAX_C   = EW2'((1 << EXP_W) - 1);
    localparam logic [W-1:0]          QNAN_C   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COZ     = 3'd1,
        ST_CARP    = 3'd2,
        ST_NORM    = 3'd3,
        ST_YUVARLA = 3'd4
    } state_t;

    state_t                  state_r;
    logic [W-1:0]            x1_r;
    logic [W-1:0]            x2_r;
    logic                    sign_r;
    logic signed [EW2-1:0]   exp_r;
    logic [MAN_W:0]          man1_r;
    logic [MAN_W:0]          man2_r;
    logic [AW-1:0]           acc_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [MAN_W-1:0]        frac_r;
    logic                    guard_r;
    logic                    sticky_r;
    logic [W-1:0]            sonuc_r;
    logic [3:0]              bayrak_r;
    logic                    gecerli_r;

    // Operand field decode (captured operands).
    logic [EXP_W-1:0]        e1_s, e2_s;
    logic [MAN_W-1:0]        f1_s, f2_s;
    logic                    sign_s;
    logic                    zero1_s, zero2_s, inf1_s, inf2_s, nan1_s, nan2_s;
    logic signed [EW2-1:0]   exp_sum_s;

    assign sign_s    = x1_r[W-1] ^ x2_r[W-1];
    assign e1_s      = x1_r[W-2:MAN_W];
    assign e2_s      = x2_r[W-2:MAN_W];
    assign f1_s      = x1_r[MAN_W-1:0];
    assign f2_s      = x2_r[MAN_W-1:0];
    assign zero1_s   = (e1_s == {EXP_W{1'b0}});
    assign zero2_s   = (e2_s == {EXP_W{1'b0}});
    assign inf1_s    = (e1_s == {EXP_W{1'b1}}) && (f1_s == {MAN_W{1'b0}});
    assign inf2_s    = (e2_s == {EXP_W{1'b1}}) && (f2_s == {MAN_W{1'b0}});
    assign nan1_s    = (e1_s == {EXP_W{1'b1}}) && (f1_s != {MAN_W{1'b0}});
    assign nan2_s    = (e2_s == {EXP_W{1'b1}}) && (f2_s != {MAN_W{1'b0}});
    assign exp_sum_s = {2'b00, e1_s} + {2'b00, e2_s} - BIAS_C;

    // Shift-add step: next BPC multiplier bits taken MSB first.
    logic [BPC-1:0]          mbits_s;
    logic [AW-1:0]           acc_next_s;

    assign mbits_s    = man2_r[MAN_W -: BPC];
    assign acc_next_s = (acc_r << BPC)
                      + ({{(AW-MAN_W-1){1'b0}}, man1_r} * {{(AW-BPC){1'b0}}, mbits_s});

    // Round-to-nearest-even and final exponent range check.
    logic                    round_up_s;
    logic [MAN_W:0]          frac_sum_s;
    logic signed [EW2-1:0]   exp_fin_s;
    logic                    of_s, uf_s, nx_s;

    assign round_up_s = guard_r & (sticky_r | frac_r[0]);
    assign frac_sum_s = {1'b0, frac_r} + {{MAN_W{1'b0}}, round_up_s};
    assign exp_fin_s  = exp_r + $signed({{(EW2-1){1'b0}}, frac_sum_s[MAN_W]});
    assign nx_s       = guard_r | sticky_r;
    assign of_s       = (exp_fin_s >= EMAX_C);
    assign uf_s       = (exp_fin_s <= $signed({EW2{1'b0}}));

    assign hazir_o   = (state_r == ST_IDLE) && !rst_i;
    assign sonuc_o   = sonuc_r;
    assign bayrak_o  = bayrak_r;
    assign gecerli_o = gecerli_r;

    // Control FSM and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            x1_r      <= {W{1'b0}};
            x2_r      <= {W{1'b0}};
            sign_r    <= 1'b0;
            exp_r     <= {EW2{1'b0}};
            man1_r    <= {(MAN_W+1){1'b0}};
            man2_r    <= {(MAN_W+1){1'b0}};
            acc_r     <= {AW{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            frac_r    <= {MAN_W{1'b0}};
            guard_r   <= 1'b0;
            sticky_r  <= 1'b0;
            sonuc_r   <= {W{1'b0}};
            bayrak_r  <= 4'b0000;
            gecerli_r <= 1'b0;
        end else begin
            gecerli_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (gecerli_i) begin
                        x1_r     <= x1_i;
                        x2_r     <= x2_i;
                        bayrak_r <= 4'b0000;
                        state_r  <= ST_COZ;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_COZ: begin
                    sign_r <= sign_s;
                    exp_r  <= exp_sum_s;
                    man1_r <= {1'b1, f1_s};
                    man2_r <= {1'b1, f2_s};
                    acc_r  <= {AW{1'b0}};
                    cnt_r  <= {CNT_W{1'b0}};
                    if (nan1_s || nan2_s || (inf1_s && zero2_s) || (inf2_s && zero1_s)) begin
                        sonuc_r   <= QNAN_C;
                        bayrak_r  <= 4'b1000;
                        gecerli_r <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else if (inf1_s || inf2_s) begin
                        sonuc_r   <= {sign_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        gecerli_r <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else if (zero1_s || zero2_s) begin
                        sonuc_r   <= {sign_s, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
                        gecerli_r <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r   <= ST_CARP;
                    end
                end
                ST_CARP: begin
                    acc_r  <= acc_next_s;
                    man2_r <= man2_r << BPC;
                    cnt_r  <= cnt_r + CNT_W'(1'b1);
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_NORM;
                    end else begin
                        state_r <= ST_CARP;
                    end
                end
                ST_NORM: begin
                    if (acc_r[AW-1]) begin
                        frac_r   <= acc_r[2*MAN_W:MAN_W+1];
                        guard_r  <= acc_r[MAN_W];
                        sticky_r <= |acc_r[MAN_W-1:0];
                        exp_r    <= exp_r + EW2'(1'b1);
                    end else begin
                        frac_r   <= acc_r[2*MAN_W-1:MAN_W];
                        guard_r  <= acc_r[MAN_W-1];
                        sticky_r <= |acc_r[MAN_W-2:0];
                    end
                    state_r <= ST_YUVARLA;
                end
                ST_YUVARLA: begin
                    if (of_s) begin
                        sonuc_r  <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        bayrak_r <= 4'b0101;
                    end else if (uf_s) begin
                        sonuc_r  <= {sign_r, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
                        bayrak_r <= 4'b0011;
                    end else begin
                        sonuc_r  <= {sign_r, exp_fin_s[EXP_W-1:0], frac_sum_s[MAN_W-1:0]};
                        bayrak_r <= {3'b000, nx_s};
                    end
                    gecerli_r <= 1'b1;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_carpma_param.sv
// Directed self-checking bench for fp_carpma_param: single and half precision
// instances, hand-computed products, flags, latency, streaming and reset abort.
module tb_fp_carpma_param;

    logic        clk_s = 1'b0;
    logic        rst_s;
    logic        gec_i_s;
    logic        hazir_s;
    logic [31:0] x1_s, x2_s, sonuc_s;
    logic        gec_o_s;
    logic [3:0]  bayrak_s;

    logic        h_gec_i_s;
    logic        h_hazir_s;
    logic [15:0] h_x1_s, h_x2_s, h_sonuc_s;
    logic        h_gec_o_s;
    logic [3:0]  h_bayrak_s;

    int n_pass  = 0;
    int n_total = 0;

    // Free-running clock.
    always #5 clk_s = ~clk_s;

    fp_carpma_param u_dut (
        .clk_i     (clk_s),
        .rst_i     (rst_s),
        .gecerli_i (gec_i_s),
        .hazir_o   (hazir_s),
        .x1_i      (x1_s),
        .x2_i      (x2_s),
        .sonuc_o   (sonuc_s),
        .gecerli_o (gec_o_s),
        .bayrak_o  (bayrak_s)
    );

    fp_carpma_param #(.EXP_W(5), .MAN_W(10), .BPC(11)) u_dut_h (
        .clk_i     (clk_s),
        .rst_i     (rst_s),
        .gecerli_i (h_gec_i_s),
        .hazir_o   (h_hazir_s),
        .x1_i      (h_x1_s),
        .x2_i      (h_x2_s),
        .sonuc_o   (h_sonuc_s),
        .gecerli_o (h_gec_o_s),
        .bayrak_o  (h_bayrak_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One transaction on the selected instance; checks latency, result, flags, pulse width.
    task automatic run_op(input string tag, input bit half, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic [3:0] exp_flg, input int exp_lat);
        int   lat;
        logic got;
        @(negedge clk_s);
        if (half) begin
            chk({tag, "_hazir"}, {31'd0, h_hazir_s}, 32'd1);
            h_gec_i_s = 1'b1; h_x1_s = a[15:0]; h_x2_s = b[15:0];
        end else begin
            chk({tag, "_hazir"}, {31'd0, hazir_s}, 32'd1);
            gec_i_s = 1'b1; x1_s = a; x2_s = b;
        end
        @(posedge clk_s); #1;
        h_gec_i_s = 1'b0;
        gec_i_s   = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clk_s); #1;
            lat++;
            got = half ? h_gec_o_s : gec_o_s;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        if (half) begin
            chk({tag, "_res"}, {16'd0, h_sonuc_s}, exp_res);
            chk({tag, "_flg"}, {28'd0, h_bayrak_s}, {28'd0, exp_flg});
        end else begin
            chk({tag, "_res"}, sonuc_s, exp_res);
            chk({tag, "_flg"}, {28'd0, bayrak_s}, {28'd0, exp_flg});
        end
        @(posedge clk_s); #1;
        chk({tag, "_pulse"}, {31'd0, (half ? h_gec_o_s : gec_o_s)}, 32'd0);
    endtask

    logic [31:0] sa [3];
    logic [31:0] sb [3];
    logic [31:0] sr [3];

    // Directed stimulus sequence.
    initial begin
        int lat;
        int pulses;
        rst_s = 1'b1; gec_i_s = 1'b0; x1_s = 32'd0; x2_s = 32'd0;
        h_gec_i_s = 1'b0; h_x1_s = 16'd0; h_x2_s = 16'd0;
        sa[0] = 32'h3FC00000; sb[0] = 32'h40000000; sr[0] = 32'h40400000;
        sa[1] = 32'h3F800001; sb[1] = 32'h3F800001; sr[1] = 32'h3F800002;
        sa[2] = 32'h3F800001; sb[2] = 32'h3FC00000; sr[2] = 32'h3FC00002;

        repeat (2) @(posedge clk_s);
        #1;
        chk("rst_sonuc",  sonuc_s, 32'd0);
        chk("rst_bayrak", {28'd0, bayrak_s}, 32'd0);
        chk("rst_gec",    {31'd0, gec_o_s}, 32'd0);
        chk("rst_hazir",  {31'd0, hazir_s}, 32'd0);
        rst_s = 1'b0;
        #1;
        chk("idle_hazir", {31'd0, hazir_s}, 32'd1);

        run_op("basic",  1'b0, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 27);
        run_op("rnd",    1'b0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 27);
        run_op("tie",    1'b0, 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 27);
        run_op("ovf",    1'b0, 32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, 27);
        run_op("unf",    1'b0, 32'h80800000, 32'h3F000000, 32'h80000000, 4'b0011, 27);
        run_op("infx0",  1'b0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 1);
        run_op("nan",    1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1);
        run_op("ninf",   1'b0, 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1);
        run_op("zero",   1'b0, 32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 1);

        // Streaming: gecerli_i held high, next accept on the result cycle.
        @(negedge clk_s);
        gec_i_s = 1'b1; x1_s = sa[0]; x2_s = sb[0];
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_s); #1;
            if (k < 2) begin
                x1_s = sa[k+1]; x2_s = sb[k+1];
            end else begin
                gec_i_s = 1'b0;
            end
            lat = 0;
            while (!gec_o_s && lat < 100) begin
                @(posedge clk_s); #1;
                lat++;
            end
            chk($sformatf("strm%0d_lat", k), lat, 27);
            chk($sformatf("strm%0d_res", k), sonuc_s, sr[k]);
            chk($sformatf("strm%0d_hazir", k), {31'd0, hazir_s}, 32'd1);
        end
        @(posedge clk_s); #1;
        chk("strm_end_gec", {31'd0, gec_o_s}, 32'd0);

        // Reset during CARP aborts the operation.
        @(negedge clk_s);
        gec_i_s = 1'b1; x1_s = 32'h3FC00000; x2_s = 32'h40000000;
        @(posedge clk_s); #1;
        gec_i_s = 1'b0;
        repeat (5) @(posedge clk_s);
        @(negedge clk_s);
        rst_s = 1'b1;
        @(posedge clk_s); #1;
        chk("abort_hazir_rst", {31'd0, hazir_s}, 32'd0);
        rst_s = 1'b0;
        #1;
        chk("abort_hazir", {31'd0, hazir_s}, 32'd1);
        chk("abort_sonuc", sonuc_s, 32'd0);
        chk("abort_bayrak", {28'd0, bayrak_s}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_s); #1;
            if (gec_o_s) pulses++;
        end
        chk("abort_pulses", pulses, 0);

        // Half precision instance.
        run_op("h_one",  1'b1, 32'h00003C00, 32'h00004000, 32'h00004000, 4'b0000, 4);
        run_op("h_ovf",  1'b1, 32'h00007BFF, 32'h00004000, 32'h00007C00, 4'b0101, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
